// File: rtl/trackball_pkg.sv
// -----------------------------------------------------------------------------
// trackball_pkg
// Shared types and helpers for the quadrature trackball counter.
//   step_t     : decoded movement between two {A,B} Gray states
//   GRAY_S0..3 : forward Gray sequence 00 -> 01 -> 11 -> 10 -> 00 ({A,B})
//   gray_next  : successor of a Gray state in the forward direction
//   quad_step  : classifies a prev -> cur transition as none/up/down/illegal
// -----------------------------------------------------------------------------
package trackball_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b01;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b10;

    function automatic logic [1:0] gray_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            GRAY_S0: n = GRAY_S1;
            GRAY_S1: n = GRAY_S2;
            GRAY_S2: n = GRAY_S3;
            default: n = GRAY_S0;
        endcase
        return n;
    endfunction

    // A change of both bits at once cannot be ordered, so it is illegal.
    function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t r;
        if (prev == cur) begin
            r = STEP_NONE;
        end else if (cur == gray_next(prev)) begin
            r = STEP_UP;
        end else if (prev == gray_next(cur)) begin
            r = STEP_DN;
        end else begin
            r = STEP_ILL;
        end
        return r;
    endfunction

endpackage

// File: rtl/quad_axis.sv
// -----------------------------------------------------------------------------
// quad_axis
// One quadrature axis: 2-flop synchroniser, per-line glitch filter sampled on
// ce, priming after reset/clear, Gray decode and a wrapping position counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   ce           : filter sample enable
//   a, b         : raw quadrature lines
//   inv          : negate the decoded direction
//   clr          : synchronous clear of count, err and primed state
//   count        : position counter (modulo 2^CNT_W)
//   err          : sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_axis #(
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             a,
    input  logic             b,
    input  logic             inv,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    import trackball_pkg::*;

    localparam int              RUN_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

    // Line order inside every 2-bit vector is {A, B}.
    logic [1:0]             meta_r;
    logic [1:0]             sync_r;
    logic [1:0]             lvl_r;
    logic [1:0][RUN_W-1:0]  run_r;
    logic [1:0]             prev_r;
    logic                   primed_r;
    logic [CNT_W-1:0]       count_r;
    logic                   err_r;

    step_t                  step_s;
    logic                   inc_s;
    logic                   dec_s;

    // Two-stage synchroniser for the asynchronous A/B lines, runs every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= {a, b};
            sync_r <= meta_r;
        end
    end

    // Glitch filter: a new level is accepted only after FILT_LEN consecutive
    // differing ce samples; any sample matching the accepted level restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_r <= 2'b00;
            run_r <= {(2 * RUN_W){1'b0}};
        end else if (ce) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] != lvl_r[i]) begin
                    if (run_r[i] == RUN_LAST) begin
                        lvl_r[i] <= sync_r[i];
                        run_r[i] <= {RUN_W{1'b0}};
                    end else begin
                        run_r[i] <= run_r[i] + RUN_W'(1);
                    end
                end else begin
                    run_r[i] <= {RUN_W{1'b0}};
                end
            end
        end
    end

    // Direction of the pending transition after the per-axis flip.
    always_comb begin
        step_s = quad_step(prev_r, lvl_r);
        inc_s  = 1'b0;
        dec_s  = 1'b0;
        case (step_s)
            STEP_UP: begin
                inc_s = ~inv;
                dec_s = inv;
            end
            STEP_DN: begin
                inc_s = inv;
                dec_s = ~inv;
            end
            default: begin
                inc_s = 1'b0;
                dec_s = 1'b0;
            end
        endcase
    end

    // Priming, counting and error capture. prev is realigned on clear so the
    // first accepted change afterwards only primes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r   <= 2'b00;
            primed_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else if (clr) begin
            prev_r   <= lvl_r;
            primed_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else if (lvl_r != prev_r) begin
            prev_r <= lvl_r;
            if (!primed_r) begin
                primed_r <= 1'b1;
            end else if (inc_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (dec_s) begin
                count_r <= count_r - CNT_W'(1);
            end else if (step_s == STEP_ILL) begin
                err_r <= 1'b1;
            end
        end
    end

    assign count = count_r;
    assign err   = err_r;

endmodule

// File: rtl/trackball_quad_counter.sv
// -----------------------------------------------------------------------------
// trackball_quad_counter
// Multi-axis quadrature trackball interface with a registered CPU read port.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   ce           : filter sample enable
//   quad_a/b     : raw phase A/B per axis
//   invert       : per-axis direction flip
//   clr          : synchronous clear of all counters and error flags
//   rd, addr     : read strobe and axis select
//   data         : registered read data, held between reads
//   err          : sticky illegal-transition flag per axis
// -----------------------------------------------------------------------------
module trackball_quad_counter #(
    parameter int NUM_AXES = 4,
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 3,
    parameter int ADDR_W   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [NUM_AXES-1:0] quad_a,
    input  logic [NUM_AXES-1:0] quad_b,
    input  logic [NUM_AXES-1:0] invert,
    input  logic                clr,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   addr,
    output logic [CNT_W-1:0]    data,
    output logic [NUM_AXES-1:0] err
);
    localparam int SEL_N = 1 << ADDR_W;

    logic [NUM_AXES-1:0][CNT_W-1:0] count_s;
    logic [NUM_AXES-1:0]            err_s;
    logic [SEL_N-1:0][CNT_W-1:0]    sel_s;
    logic [CNT_W-1:0]               data_r;

    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        quad_axis #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_axis (
            .clk     (clk),
            .reset_n (reset_n),
            .ce      (ce),
            .a       (quad_a[g]),
            .b       (quad_b[g]),
            .inv     (invert[g]),
            .clr     (clr),
            .count   (count_s[g]),
            .err     (err_s[g])
        );
    end

    // Read table padded to the full address space; unused selects read zero.
    always_comb begin
        sel_s = {(SEL_N * CNT_W){1'b0}};
        for (int i = 0; i < NUM_AXES; i++) begin
            sel_s[i] = count_s[i];
        end
    end

    // Read register: captures the counter as it was before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= {CNT_W{1'b0}};
        end else if (rd) begin
            data_r <= sel_s[addr];
        end
    end

    assign data = data_r;
    assign err  = err_s;

endmodule

// File: tb/tb_trackball_quad_counter.sv
module tb_trackball_quad_counter;

    localparam int NA = 4;
    localparam int CW = 8;
    localparam int FL = 3;
    localparam int AW = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce      = 1'b0;
    logic          clr     = 1'b0;
    logic          rd      = 1'b0;
    logic [NA-1:0] quad_a  = '0;
    logic [NA-1:0] quad_b  = '0;
    logic [NA-1:0] invert  = '0;
    logic [AW-1:0] addr    = '0;
    logic [CW-1:0] data;
    logic [CW-1:0] data3;
    logic [NA-1:0] err;
    logic [2:0]    err3;

    int n_cmp = 0;
    int n_bad = 0;

    bit ce_every = 1'b0;
    bit ce_phase = 1'b0;

    // Reference model: Gray position (0..3), priming, count and sticky error.
    int            pos    [NA];
    bit            primed [NA];
    logic [CW-1:0] mcnt   [NA];
    logic [NA-1:0] merr;

    trackball_quad_counter #(
        .NUM_AXES (NA), .CNT_W (CW), .FILT_LEN (FL), .ADDR_W (AW)
    ) dut (
        .clk (clk), .reset_n (reset_n), .ce (ce),
        .quad_a (quad_a), .quad_b (quad_b), .invert (invert),
        .clr (clr), .rd (rd), .addr (addr), .data (data), .err (err)
    );

    trackball_quad_counter #(
        .NUM_AXES (3), .CNT_W (CW), .FILT_LEN (FL), .ADDR_W (AW)
    ) dut3 (
        .clk (clk), .reset_n (reset_n), .ce (ce),
        .quad_a (quad_a[2:0]), .quad_b (quad_b[2:0]), .invert (invert[2:0]),
        .clr (clr), .rd (rd), .addr (addr), .data (data3), .err (err3)
    );

    always #50 clk = ~clk;

    // ce either every clock or every second clock
    always @(negedge clk) begin
        ce_phase = ~ce_phase;
        ce = ce_every | ce_phase;
    end

    function automatic logic [1:0] gray_of(input int p);
        logic [1:0] g;
        case (p)
            0:       g = 2'b00;
            1:       g = 2'b01;
            2:       g = 2'b11;
            default: g = 2'b10;
        endcase
        return g;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset_counts();
        for (int i = 0; i < NA; i++) begin
            primed[i] = 1'b0;
            mcnt[i]   = 8'h00;
        end
        merr = '0;
    endtask

    // Drive a new Gray position on one axis and advance the model.
    task automatic model_move(input int ax, input int newp_raw);
        int newp;
        int d;
        newp = ((newp_raw % 4) + 4) % 4;
        d = ((newp - pos[ax]) % 4 + 4) % 4;
        if (d != 0) begin
            if (!primed[ax]) begin
                primed[ax] = 1'b1;
            end else if (d == 1) begin
                mcnt[ax] = invert[ax] ? mcnt[ax] - 8'd1 : mcnt[ax] + 8'd1;
            end else if (d == 3) begin
                mcnt[ax] = invert[ax] ? mcnt[ax] + 8'd1 : mcnt[ax] - 8'd1;
            end else begin
                merr[ax] = 1'b1;
            end
        end
        pos[ax] = newp;
        {quad_a[ax], quad_b[ax]} = gray_of(newp);
    endtask

    task automatic check8(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_err();
        n_cmp++;
        assert (err === merr) else begin
            n_bad++;
            $error("FAIL err got=%b exp=%b", err, merr);
        end
        n_cmp++;
        assert (err3 === merr[2:0]) else begin
            n_bad++;
            $error("FAIL err3 got=%b exp=%b", err3, merr[2:0]);
        end
    endtask

    // Read one axis from both builds; call at a negedge.
    task automatic read_axis(input int ax);
        logic [CW-1:0] exp3;
        rd   = 1'b1;
        addr = AW'(ax);
        @(negedge clk);
        rd = 1'b0;
        exp3 = (ax < 3) ? mcnt[ax] : 8'h00;
        check8($sformatf("rd_ax%0d", ax), data, mcnt[ax]);
        check8($sformatf("rd3_ax%0d", ax), data3, exp3);
    endtask

    task automatic read_all();
        for (int ax = 0; ax < NA; ax++) begin
            read_axis(ax);
        end
        check_err();
    endtask

    initial begin
        logic [CW-1:0] exp_old;
        int r;

        for (int i = 0; i < NA; i++) pos[i] = 0;
        model_reset_counts();

        // Reset state
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        read_all();

        // Axis 0 forward cycle: first change primes, remaining three count
        model_move(0, 1); wait_clk(12);
        model_move(0, 2); wait_clk(12);
        model_move(0, 3); wait_clk(12);
        model_move(0, 0); wait_clk(12);
        read_axis(0);
        check8("ax0_fwd_const", data, 8'h03);
        check_err();

        // Glitch on axis 1: two ce samples of A high is rejected
        model_move(1, 1); wait_clk(12);
        quad_a[1] = 1'b1; wait_clk(4);
        quad_a[1] = 1'b0; wait_clk(12);
        read_axis(1);
        check_err();
        model_move(1, 2); wait_clk(12);
        read_axis(1);
        check8("ax1_after_hold", data, 8'h01);

        // Wrap on axis 2 with ce every clock
        ce_every = 1'b1; wait_clk(2);
        model_move(2, 1); wait_clk(10);
        for (int k = 0; k < 255; k++) begin
            model_move(2, pos[2] + 3); wait_clk(8);
        end
        read_axis(2);
        check8("ax2_preload", data, 8'h01);
        model_move(2, pos[2] + 3); wait_clk(8); read_axis(2);
        model_move(2, pos[2] + 3); wait_clk(8); read_axis(2);
        check8("ax2_wrap_dn", data, 8'hFF);
        model_move(2, pos[2] + 1); wait_clk(8); read_axis(2);
        check8("ax2_wrap_up", data, 8'h00);
        invert[2] = 1'b1; wait_clk(2);
        model_move(2, pos[2] + 1); wait_clk(8); read_axis(2);
        check8("ax2_inv", data, 8'hFF);
        model_move(2, pos[2] + 3); wait_clk(8); read_axis(2);

        // Illegal jump on axis 3
        model_move(3, 1); wait_clk(10);
        model_move(3, 3); wait_clk(10);
        read_axis(3);
        check_err();
        n_cmp++;
        assert (err === 4'b1000) else begin
            n_bad++;
            $error("FAIL err_ill got=%b exp=%b", err, 4'b1000);
        end

        // clr coincident with a valid step on axis 0 (counter edge is 6th)
        model_move(0, pos[0] + 1);
        wait_clk(5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset_counts();
        wait_clk(4);
        read_all();

        // Read on the very edge where count[0] goes 5 -> 6
        model_move(0, pos[0] + 1); wait_clk(10);
        for (int k = 0; k < 5; k++) begin
            model_move(0, pos[0] + 1); wait_clk(10);
        end
        read_axis(0);
        exp_old = mcnt[0];
        model_move(0, pos[0] + 1);
        wait_clk(5);
        rd   = 1'b1;
        addr = 2'd0;
        @(negedge clk);
        rd = 1'b0;
        check8("collide_old", data, exp_old);
        wait_clk(1);
        read_axis(0);
        check8("collide_new", data, 8'h06);
        read_axis(3);

        // Randomised movement on all axes
        for (int it = 0; it < 40; it++) begin
            ce_every = ($urandom_range(0, 1) == 1);
            for (int ax = 0; ax < NA; ax++) begin
                r = $urandom_range(0, 11);
                if (r < 3) invert[ax] = ~invert[ax];
                if (r >= 3 && r < 7) model_move(ax, pos[ax] + 1);
                else if (r >= 7 && r < 10) model_move(ax, pos[ax] + 3);
                else if (r >= 10) model_move(ax, pos[ax] + 2);
            end
            wait_clk(14);
            read_all();
        end

        // Asynchronous reset in the middle of a step
        model_move(1, pos[1] + 1);
        wait_clk(3);
        #10 reset_n = 1'b0;
        wait_clk(2);
        quad_a = '0;
        quad_b = '0;
        for (int i = 0; i < NA; i++) pos[i] = 0;
        model_reset_counts();
        reset_n = 1'b1;
        wait_clk(14);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
